// File: rtl/dff_reg_arbiter.sv
// dff_reg_arbiter: round-robin write arbiter in front of a shared WIDTH-bit register.
// One requester per clock may load the register. Its data is captured on the same
// edge that raises its one-cycle grant pulse.
module dff_reg_arbiter #(
    parameter  int WIDTH = 8,
    parameter  int NREQ  = 4,
    localparam int IDXW  = $clog2(NREQ)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] d_in,
    output logic [NREQ-1:0]       grant,
    output logic [IDXW-1:0]       owner,
    output logic                  valid,
    output logic [WIDTH-1:0]      Q_out,
    output logic [WIDTH-1:0]      Qb_out
);

    // Requester with the highest priority for the next arbitration.
    logic [IDXW-1:0]  ptr;

    // Combinational arbitration results for the upcoming edge.
    logic [NREQ-1:0]  eff;
    logic             found;
    logic [IDXW-1:0]  winIdx;
    logic [NREQ-1:0]  grantNext;
    logic [WIDTH-1:0] winData;
    logic [IDXW-1:0]  ptrNext;

    // Mask last cycle's winner, then pick the first active request at or after ptr with wrap.
    always_comb begin
        int idx;
        eff       = req & ~grant;
        found     = 1'b0;
        winIdx    = '0;
        grantNext = '0;
        winData   = '0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && eff[idx]) begin
                found          = 1'b1;
                winIdx         = IDXW'(idx);
                grantNext[idx] = 1'b1;
                winData        = d_in[idx*WIDTH +: WIDTH];
            end
        end
    end

    // The requester just after the winner gets top priority next; the last index wraps to zero.
    always_comb begin
        ptrNext = ptr;
        if (found) begin
            if (int'(winIdx) == NREQ - 1) begin
                ptrNext = '0;
            end else begin
                ptrNext = winIdx + 1'b1;
            end
        end
    end

    // State register: reset takes precedence over any request in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            Q_out <= '0;
            grant <= '0;
            owner <= '0;
            valid <= 1'b0;
            ptr   <= '0;
        end else if (found) begin
            Q_out <= winData;
            grant <= grantNext;
            owner <= winIdx;
            valid <= 1'b1;
            ptr   <= ptrNext;
        end else begin
            grant <= '0;
        end
    end

    // The complement is taken straight from the register, so it always matches Q_out.
    assign Qb_out = ~Q_out;

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Directed testbench for dff_reg_arbiter (WIDTH=8, NREQ=4).
// Each scenario task drives its inputs and checks the outputs 1 ns after the rising edge.
module tb_dff_reg_arbiter;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;

    logic             clock;
    logic             reset;
    logic [3:0]       req;
    logic [31:0]      d_in;
    logic [3:0]       grant;
    logic [1:0]       owner;
    logic             valid;
    logic [7:0]       Q_out;
    logic [7:0]       Qb_out;

    int checks;
    int errors;

    dff_reg_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clock  (clock),
        .reset  (reset),
        .req    (req),
        .d_in   (d_in),
        .grant  (grant),
        .owner  (owner),
        .valid  (valid),
        .Q_out  (Q_out),
        .Qb_out (Qb_out)
    );

    // Free-running 10 ns clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge, then settle before the outputs are sampled.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Load the four lanes of packed write data.
    task automatic setData(input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] d3);
        d_in = {d3, d2, d1, d0};
    endtask

    // Reset held for two edges overrides all requests; requester 0 wins first after release.
    task automatic test_reset();
        setData(8'h10, 8'h11, 8'h12, 8'h13);
        reset = 1'b1;
        req   = 4'b1111;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (Q_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_q: got %h expected 00", Q_out); end
            checks++;
            if (Qb_out !== 8'hFF) begin errors++; $display("[TB] FAIL reset_qb: got %h expected ff", Qb_out); end
            checks++;
            if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL reset_grant: got %b expected 0000", grant); end
            checks++;
            if (valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", valid); end
        end
        reset = 1'b0;
        tick();
        checks++;
        if (grant !== 4'b0001) begin errors++; $display("[TB] FAIL reset_first_grant: got %b expected 0001", grant); end
        checks++;
        if (Q_out !== 8'h10) begin errors++; $display("[TB] FAIL reset_first_q: got %h expected 10", Q_out); end
        checks++;
        if (owner !== 2'd0) begin errors++; $display("[TB] FAIL reset_first_owner: got %0d expected 0", owner); end
        checks++;
        if (valid !== 1'b1) begin errors++; $display("[TB] FAIL reset_first_valid: got %b expected 1", valid); end
        req = 4'b0000;
        tick();
        checks++;
        if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL reset_idle_grant: got %b expected 0000", grant); end
    endtask

    // A lone requester gets one pulse and the register then holds its data.
    task automatic test_single();
        setData(8'h00, 8'h00, 8'hA5, 8'h00);
        req = 4'b0100;
        tick();
        checks++;
        if (grant !== 4'b0100) begin errors++; $display("[TB] FAIL single_grant: got %b expected 0100", grant); end
        checks++;
        if (Q_out !== 8'hA5) begin errors++; $display("[TB] FAIL single_q: got %h expected a5", Q_out); end
        checks++;
        if (Qb_out !== 8'h5A) begin errors++; $display("[TB] FAIL single_qb: got %h expected 5a", Qb_out); end
        checks++;
        if (owner !== 2'd2) begin errors++; $display("[TB] FAIL single_owner: got %0d expected 2", owner); end
        checks++;
        if (valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid: got %b expected 1", valid); end
        req = 4'b0000;
        setData(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL single_hold_grant: got %b expected 0000", grant); end
            checks++;
            if (Q_out !== 8'hA5) begin errors++; $display("[TB] FAIL single_hold_q: got %h expected a5", Q_out); end
        end
    endtask

    // All four requesting continuously rotate the grant from requester 0 upward.
    task automatic test_rotation();
        logic [3:0] expGrant [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                    4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [7:0] expQ [8]     = '{8'h10, 8'h11, 8'h12, 8'h13,
                                    8'h10, 8'h11, 8'h12, 8'h13};
        reset = 1'b1;
        req   = 4'b0000;
        tick();
        reset = 1'b0;
        setData(8'h10, 8'h11, 8'h12, 8'h13);
        req = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            tick();
            checks++;
            if (grant !== expGrant[c]) begin errors++; $display("[TB] FAIL rotation_grant[%0d]: got %b expected %b", c, grant, expGrant[c]); end
            checks++;
            if (Q_out !== expQ[c]) begin errors++; $display("[TB] FAIL rotation_q[%0d]: got %h expected %h", c, Q_out, expQ[c]); end
        end
        req = 4'b0000;
        tick();
    endtask

    // A lone continuous requester 3 is masked every other cycle; requester 0 then wins after the wrap.
    task automatic test_wrap();
        logic [3:0] expGrant [4] = '{4'b1000, 4'b0000, 4'b1000, 4'b0000};
        setData(8'h20, 8'h21, 8'h22, 8'h23);
        req = 4'b1000;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (grant !== expGrant[c]) begin errors++; $display("[TB] FAIL wrap_grant[%0d]: got %b expected %b", c, grant, expGrant[c]); end
        end
        req = 4'b1001;
        tick();
        checks++;
        if (grant !== 4'b0001) begin errors++; $display("[TB] FAIL wrap_req0_grant: got %b expected 0001", grant); end
        checks++;
        if (owner !== 2'd0) begin errors++; $display("[TB] FAIL wrap_req0_owner: got %0d expected 0", owner); end
        checks++;
        if (Q_out !== 8'h20) begin errors++; $display("[TB] FAIL wrap_req0_q: got %h expected 20", Q_out); end
        tick();
        checks++;
        if (grant !== 4'b1000) begin errors++; $display("[TB] FAIL wrap_req3_grant: got %b expected 1000", grant); end
        checks++;
        if (Q_out !== 8'h23) begin errors++; $display("[TB] FAIL wrap_req3_q: got %h expected 23", Q_out); end
        req = 4'b0000;
        tick();
    endtask

    // Reset asserted while requesters 1 and 2 are eligible cancels the write and restarts at ptr=0.
    task automatic test_mid_reset();
        setData(8'h30, 8'h31, 8'h32, 8'h33);
        req = 4'b0010;
        tick();
        req = 4'b0000;
        tick();
        req   = 4'b0110;
        reset = 1'b1;
        tick();
        checks++;
        if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL midreset_grant: got %b expected 0000", grant); end
        checks++;
        if (Q_out !== 8'h00) begin errors++; $display("[TB] FAIL midreset_q: got %h expected 00", Q_out); end
        checks++;
        if (valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_valid: got %b expected 0", valid); end
        reset = 1'b0;
        tick();
        checks++;
        if (grant !== 4'b0010) begin errors++; $display("[TB] FAIL midreset_first_grant: got %b expected 0010", grant); end
        checks++;
        if (Q_out !== 8'h31) begin errors++; $display("[TB] FAIL midreset_first_q: got %h expected 31", Q_out); end
        tick();
        checks++;
        if (grant !== 4'b0100) begin errors++; $display("[TB] FAIL midreset_second_grant: got %b expected 0100", grant); end
        req = 4'b0000;
        tick();
    endtask

    // With ptr=2 and req=1011, the grant order is 3, 0, 1.
    task automatic test_back_to_back();
        logic [3:0] expGrant [3] = '{4'b1000, 4'b0001, 4'b0010};
        logic [1:0] expOwner [3] = '{2'd3, 2'd0, 2'd1};
        logic [7:0] expQ [3]     = '{8'h43, 8'h40, 8'h41};
        reset = 1'b1;
        tick();
        reset = 1'b0;
        setData(8'h40, 8'h41, 8'h42, 8'h43);
        req = 4'b0010;
        tick();
        req = 4'b0000;
        tick();
        req = 4'b1011;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (grant !== expGrant[c]) begin errors++; $display("[TB] FAIL b2b_grant[%0d]: got %b expected %b", c, grant, expGrant[c]); end
            checks++;
            if (owner !== expOwner[c]) begin errors++; $display("[TB] FAIL b2b_owner[%0d]: got %0d expected %0d", c, owner, expOwner[c]); end
            checks++;
            if (Q_out !== expQ[c]) begin errors++; $display("[TB] FAIL b2b_q[%0d]: got %h expected %h", c, Q_out, expQ[c]); end
            checks++;
            if (Qb_out !== ~expQ[c]) begin errors++; $display("[TB] FAIL b2b_qb[%0d]: got %h expected %h", c, Qb_out, ~expQ[c]); end
        end
        req = 4'b0000;
        tick();
    endtask

    // Run every scenario in order and report the totals.
    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        req    = 4'b0000;
        d_in   = '0;
        test_reset();
        test_single();
        test_rotation();
        test_wrap();
        test_mid_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dff_reg_arbiter.md
# dff_reg_arbiter

Round-robin write arbiter for a shared WIDTH-bit D-flip-flop register. Up to NREQ requesters compete to load the register. The block grants at most one writer per clock and captures the winner's data on the same edge. It drives the register outputs Q_out/Qb_out directly, so downstream logic sees a single owned state register with a registered grant handshake.

## Interface
- WIDTH, 8, data width of the shared register (≥1)
- NREQ, 4, number of requesters (2..8)
- IDXW, $clog2(NREQ), width of owner index (derived, not overridden)
- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req  input  NREQ  per-requester write request, level, held until granted
- d_in  input  NREQ*WIDTH  packed write data; requester i on bits [i*WIDTH +: WIDTH]
- grant  output  NREQ  registered one-hot grant pulse, one cycle wide
- owner  output  IDXW  index of the last requester whose data was written
- valid  output  1  high once the register has been written since reset
- Q_out  output  WIDTH  shared register contents
- Qb_out  output  WIDTH  bitwise complement of Q_out, always ~Q_out

## Operation
- Reset (reset=1 at a rising edge) sets the following, overriding any req in that cycle:
  - Q_out=0, Qb_out={WIDTH{1}}, grant=0, owner=0, valid=0.
  - Round-robin pointer ptr=0, meaning requester 0 has highest priority.
- Masking: the effective request is eff[i] = req[i] & ~grant[i]. The requester granted in the previous cycle is ignored for one cycle, which gives it time to drop req.
- Arbitration is combinational over eff, searching from ptr upward with wrap-around (ptr, ptr+1, …, NREQ-1, 0, …, ptr-1). The first set bit wins.
- When a winner w exists, the next rising edge:
  - sets Q_out=d_in[w], grant=one-hot(w), owner=w, valid=1;
  - sets ptr=(w+1) mod NREQ.
- When there is no winner, the next rising edge:
  - sets grant=0;
  - holds Q_out, owner, valid and ptr.
- Requester protocol:
  - Hold req and d_in stable until grant[i] is seen high.
  - Deassert req in the grant cycle, or reassert it deliberately for a new write.
  - If req[i] is still high in the cycle after grant, it competes again as a fresh request at the priority given by ptr.
- Fairness: a continuously requesting requester waits at most NREQ-1 other grants.
- Data in a cycle where the requester is not the winner is ignored; no queuing of data.

## Timing
- Latency is 1 cycle. req sampled at edge k → Q_out updated and grant high after edge k (during cycle k+1).
- Throughput is one write per cycle when two or more requesters are active. A single requester that holds req continuously writes every other cycle because of masking.
- Simultaneous requests resolve purely by ptr; ties are impossible.
- Wrap-around: ptr=NREQ-1 with winner NREQ-1 → ptr becomes 0.
- Reset mid-operation:
  - A pending grant is cancelled in the same edge, and there is no write in that cycle.
  - Requests still high after reset are arbitrated from ptr=0 on the next edge.
- Qb_out is ~Q_out combinationally from the register; it never shows a transient mismatch at clock edges.

## Test plan
- Reset behaviour, WIDTH=8, NREQ=4:
  - Stimulus: reset=1 for 2 cycles while req=4'b1111.
  - Required response: Q_out=8'h00, Qb_out=8'hFF, grant=0, valid=0 throughout. On the first edge after release, grant=4'b0001, Q_out=d_in[0], owner=0.
- Single requester:
  - Stimulus: req=4'b0100 with d_in[2]=8'hA5, dropped in the grant cycle.
  - Required response: one grant pulse 4'b0100, Q_out=8'hA5, Qb_out=8'h5A, owner=2, valid=1. Q_out holds afterwards with grant=0.
- Round-robin rotation:
  - Stimulus: req=4'b1111 held constantly, with data 8'h10/8'h11/8'h12/8'h13.
  - Required response: grant sequence 0001, 0010, 0100, 1000, 0001…; Q_out follows 10, 11, 12, 13, 10….
- Wrap and masking:
  - Stimulus: only req[3] held high continuously.
  - Required response: grant alternates 1000, 0000, 1000…; ptr wraps to 0. When req[0] is raised, it wins the next free slot ahead of req[3].
- Reset mid-operation:
  - Stimulus: assert reset in the cycle where eff=4'b0110.
  - Required response: no write; Q_out=0, grant=0. After release, requester 1 wins first (ptr=0).
- Simultaneous release:
  - Stimulus: ptr=2, req=4'b1011.
  - Required response: requester 3 wins, then requester 0 (ptr=0), then requester 1.
